// File: rtl/efpga_resp_pkg.sv
// Shared definitions for the eFPGA custom-instruction responder:
// operator codes, FSM state encoding and the accumulate helper.
// Optional feature macro: EFPGA_MAC_SAT_EN (saturating MAC accumulate).
package efpga_resp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Accumulator update for the MAC operation: unsigned-saturating when
  // EFPGA_MAC_SAT_EN is defined, wrapping modulo 2^32 otherwise.
  function automatic logic [31:0] mac_accumulate(input logic [31:0] acc,
                                                 input logic [31:0] prod);
`ifdef EFPGA_MAC_SAT_EN
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, prod};
    mac_accumulate = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
    mac_accumulate = acc + prod;
`endif
  endfunction

endpackage

// File: rtl/efpga_op_responder_if.sv
// Handshake/data bundle between the core-side requester (master) and the
// fabric-side responder (slave).
interface efpga_op_responder_if;
  logic        en;
  logic [1:0]  operator;
  logic        write_strobe;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result_a;
  logic [31:0] result_b;
  logic [31:0] result_c;
  logic        efpga_done;
  logic        busy;

  modport master (
    output en, operator, write_strobe, operand_a, operand_b,
    input  result_a, result_b, result_c, efpga_done, busy
  );

  modport slave (
    input  en, operator, write_strobe, operand_a, operand_b,
    output result_a, result_b, result_c, efpga_done, busy
  );
endinterface

// File: rtl/efpga_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// 'start' loads the operands; 'valid' is high during the final step, when
// 'product' already contains the complete low 32 bits of a*b.
module efpga_iter_mul #(
  parameter int unsigned MUL_STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        valid
);

  localparam int unsigned STEPS = 32 / MUL_STEP;
  localparam int unsigned CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  logic [31:0]   a_sh_r;
  logic [31:0]   b_sh_r;
  logic [31:0]   partial_r;
  logic [CW-1:0] cnt_r;
  logic          run_r;
  logic [31:0]   term_s;
  logic          last_s;

  // Partial product contributed by the low MUL_STEP bits of the multiplier.
  always_comb begin
    term_s = a_sh_r * 32'(b_sh_r[MUL_STEP-1:0]);
    last_s = run_r && (cnt_r == LAST_CNT);
  end

  assign product = partial_r + term_s;
  assign valid   = last_s;

  // Operand shift registers, running sum and step counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh_r    <= 32'd0;
      b_sh_r    <= 32'd0;
      partial_r <= 32'd0;
      cnt_r     <= '0;
      run_r     <= 1'b0;
    end else if (start) begin
      a_sh_r    <= a;
      b_sh_r    <= b;
      partial_r <= 32'd0;
      cnt_r     <= '0;
      run_r     <= 1'b1;
    end else if (run_r) begin
      a_sh_r    <= a_sh_r << MUL_STEP;
      b_sh_r    <= b_sh_r >> MUL_STEP;
      partial_r <= partial_r + term_s;
      cnt_r     <= cnt_r + CW'(1);
      if (last_s) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/efpga_op_responder.sv
// Fabric-side responder for the eFPGA custom-instruction handshake.
// Detects the rising edge of en, runs add / iterative multiply / MAC /
// accumulator write, and returns results with a one-cycle done pulse.
// Optional feature macro: EFPGA_MAC_SAT_EN (saturating MAC accumulate).
module efpga_op_responder
  import efpga_resp_pkg::*;
#(
  parameter int unsigned MUL_STEP = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  efpga_op_responder_if.slave   bus
);

  state_e      state_r;
  state_e      state_nxt_s;
  logic        en_q_r;
  logic        start_s;
  logic        mul_start_s;
  logic [1:0]  op_r;
  logic [31:0] acc_r;
  logic [31:0] res_a_r;
  logic [31:0] res_b_r;
  logic [31:0] res_c_r;
  logic [31:0] mul_product_s;
  logic        mul_valid_s;
  logic [31:0] mac_sum_s;

  assign start_s   = bus.en & ~en_q_r;
  assign mac_sum_s = mac_accumulate(acc_r, mul_product_s);

  efpga_iter_mul #(
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start   (mul_start_s),
    .a       (bus.operand_a),
    .b       (bus.operand_b),
    .product (mul_product_s),
    .valid   (mul_valid_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; starts are honoured only from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    mul_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if ((bus.operator == OP_MUL) || (bus.operator == OP_MAC)) begin
            state_nxt_s = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_valid_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Edge detector, operator latch, accumulator and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q_r  <= 1'b0;
      op_r    <= OP_ADD;
      acc_r   <= 32'd0;
      res_a_r <= 32'd0;
      res_b_r <= 32'd0;
      res_c_r <= 32'd0;
    end else begin
      en_q_r <= bus.en;
      if ((state_r == ST_IDLE) && start_s) begin
        op_r <= bus.operator;
        case (bus.operator)
          OP_ADD: res_a_r <= bus.operand_a + bus.operand_b;
          OP_WR: begin
            res_a_r <= bus.operand_a;
            if (bus.write_strobe) begin
              acc_r <= bus.operand_a;
            end
          end
          default: begin
            // Multiply/MAC results are written when the multiplier finishes.
          end
        endcase
      end else if ((state_r == ST_MUL) && mul_valid_s) begin
        if (op_r == OP_MUL) begin
          res_b_r <= mul_product_s;
        end else if (op_r == OP_MAC) begin
          acc_r   <= mac_sum_s;
          res_c_r <= mac_sum_s;
        end
      end
    end
  end

  assign bus.result_a   = res_a_r;
  assign bus.result_b   = res_b_r;
  assign bus.result_c   = res_c_r;
  assign bus.efpga_done = (state_r == ST_DONE);
  assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_efpga_op_responder.sv
// Self-checking bench for efpga_op_responder: table-driven vectors through a
// scoreboard queue, a short random multiply/add run, and hand-written
// sequences for en hold, mid-multiply re-trigger and mid-operation reset.
module tb_efpga_op_responder;
  import efpga_resp_pkg::*;

  localparam int unsigned MUL_STEP = 4;
  localparam int LAT_SHORT = 1;
  localparam int LAT_MUL   = 1 + 32 / MUL_STEP;
`ifdef EFPGA_MAC_SAT_EN
  localparam logic [31:0] SAT_C = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SAT_C = 32'h0000_0010;
`endif

  logic clk;
  logic rst_ni;
  efpga_op_responder_if bus ();

  efpga_op_responder #(.MUL_STEP(MUL_STEP)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        strobe;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_c;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   fails;
  logic [31:0] m_a, m_b, m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the done pulse, then pop and compare the expectation.
  // glitch>0 drops en at that negedge and raises it again one cycle later
  // with an add request that must be ignored.
  task automatic wait_done(input string name, input int glitch);
    exp_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (glitch != 0 && n == glitch) bus.en = 1'b0;
      if (glitch != 0 && n == glitch + 1) begin
        bus.en = 1'b1;
        bus.operator = OP_ADD;
        bus.operand_a = 32'd1;
        bus.operand_b = 32'd1;
      end
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.efpga_done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_latency"}, 32'(n), 32'(e.lat));
      chk({name, "_res_a"}, bus.result_a, e.a);
      chk({name, "_res_b"}, bus.result_b, e.b);
      chk({name, "_res_c"}, bus.result_c, e.c);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic strobe,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ec, input int lat,
                        input int glitch, input bit keep_en);
    exp_t e;
    e.a = ea; e.b = eb; e.c = ec; e.lat = lat;
    sb_q.push_back(e);
    bus.operator = op;
    bus.write_strobe = strobe;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.en = 1'b1;
    wait_done(name, glitch);
    if (!keep_en) bus.en = 1'b0;
    @(negedge clk);
    chk({name, "_done_clr"}, 32'(bus.efpga_done), 32'd0);
    chk({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic count_pulses(input string name, input int cycles, input int exp);
    int p;
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.efpga_done) p++;
    end
    chk(name, 32'(p), 32'(exp));
  endtask

  vec_t vecs[11];

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = '{OP_ADD, 1'b0, 32'd5,          32'd7,          32'd12,         32'd0,          32'd0,   LAT_SHORT};
    vecs[1]  = '{OP_ADD, 1'b0, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'd0,          32'd0,   LAT_SHORT};
    vecs[2]  = '{OP_MUL, 1'b0, 32'h0001_0003,  32'd5,          32'd1,          32'h0005_000F,  32'd0,   LAT_MUL};
    vecs[3]  = '{OP_MUL, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0,   LAT_MUL};
    vecs[4]  = '{OP_WR,  1'b1, 32'd100,        32'd0,          32'd100,        32'd1,          32'd0,   LAT_SHORT};
    vecs[5]  = '{OP_MAC, 1'b0, 32'd3,          32'd4,          32'd100,        32'd1,          32'd112, LAT_MUL};
    vecs[6]  = '{OP_MAC, 1'b0, 32'd3,          32'd4,          32'd100,        32'd1,          32'd124, LAT_MUL};
    vecs[7]  = '{OP_WR,  1'b0, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  32'd1,          32'd124, LAT_SHORT};
    vecs[8]  = '{OP_MAC, 1'b0, 32'd1,          32'd1,          32'hDEAD_BEEF,  32'd1,          32'd125, LAT_MUL};
    vecs[9]  = '{OP_WR,  1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  32'd1,          32'd125, LAT_SHORT};
    vecs[10] = '{OP_MAC, 1'b0, 32'd4,          32'd8,          32'hFFFF_FFF0,  32'd1,          SAT_C,   LAT_MUL};

    rst_ni = 1'b0;
    bus.en = 1'b0;
    bus.operator = OP_ADD;
    bus.write_strobe = 1'b0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_res_a", bus.result_a, 32'd0);
    chk("reset_res_b", bus.result_b, 32'd0);
    chk("reset_res_c", bus.result_c, 32'd0);
    chk("reset_done", 32'(bus.efpga_done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].strobe, vecs[i].a, vecs[i].b,
             vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c, vecs[i].lat, 0, 1'b0);
    end

    // Random multiplies and adds against a reference model.
    m_a = 32'hFFFF_FFF0;
    m_b = 32'd1;
    m_c = SAT_C;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      m_b = ra * rb;
      run_op($sformatf("rmul%0d", i), OP_MUL, 1'b0, ra, rb, m_a, m_b, m_c, LAT_MUL, 0, 1'b0);
      ra = $urandom;
      rb = $urandom;
      m_a = ra + rb;
      run_op($sformatf("radd%0d", i), OP_ADD, 1'b0, ra, rb, m_a, m_b, m_c, LAT_SHORT, 0, 1'b0);
    end

    // en held high after an add: exactly one done pulse.
    m_a = 32'd30;
    run_op("hold_add", OP_ADD, 1'b0, 32'd10, 32'd20, m_a, m_b, m_c, LAT_SHORT, 0, 1'b1);
    count_pulses("hold_extra_pulses", 20, 0);
    bus.en = 1'b0;
    @(negedge clk);

    // Second en edge during MUL is ignored; busy stays high until DONE.
    m_b = 32'd15;
    run_op("retrig_mul", OP_MUL, 1'b0, 32'd3, 32'd5, m_a, m_b, m_c, LAT_MUL, 2, 1'b1);
    count_pulses("retrig_extra_pulses", 6, 0);
    chk("retrig_res_a", bus.result_a, m_a);
    bus.en = 1'b0;
    @(negedge clk);

    // Reset during the fourth MUL cycle aborts without a done pulse.
    bus.operator = OP_MUL;
    bus.operand_a = 32'd7;
    bus.operand_b = 32'd9;
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_res_a", bus.result_a, 32'd0);
    chk("arst_res_b", bus.result_b, 32'd0);
    chk("arst_res_c", bus.result_c, 32'd0);
    chk("arst_done", 32'(bus.efpga_done), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    count_pulses("arst_no_done", 12, 0);
    run_op("post_rst_add", OP_ADD, 1'b0, 32'd2, 32'd3, 32'd5, 32'd0, 32'd0, LAT_SHORT, 0, 1'b0);
    run_op("post_rst_mac", OP_MAC, 1'b0, 32'd2, 32'd3, 32'd5, 32'd0, 32'd6, LAT_MUL, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
